// File: rtl/memory_access_unit.sv
// MEM-stage data path: byte-lane steering of loads/stores to a req/ack memory, with alignment and timeout faults.
// Latency 1 for non-memory ops and faults, >=2 for memory ops; o_stall holds upstream while a request is pending.
module memory_access_unit #(
   parameter int NB_DATA        = 32,
   parameter int NB_BYTE        = 8,
   parameter int NB_ADDR        = 32,
   parameter int NB_SIZE        = 2,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int NB_TIMEOUT     = 5
) (
   input  logic                       i_clock,
   input  logic                       i_reset,
   input  logic                       i_valid,
   input  logic                       i_read_enable,
   input  logic                       i_write_enable,
   input  logic [NB_SIZE-1:0]         i_size,
   input  logic                       i_is_unsigned,
   input  logic [NB_ADDR-1:0]         i_address,
   input  logic [NB_DATA-1:0]         i_data_write,
   output logic                       o_stall,
   output logic                       o_valid,
   output logic [NB_DATA-1:0]         o_data,
   output logic                       o_misaligned,
   output logic                       o_timeout,
   output logic                       o_mem_req,
   output logic                       o_mem_we,
   output logic [NB_ADDR-1:0]         o_mem_addr,
   output logic [NB_DATA/NB_BYTE-1:0] o_mem_byte_en,
   output logic [NB_DATA-1:0]         o_mem_wdata,
   input  logic                       i_mem_ack,
   input  logic [NB_DATA-1:0]         i_mem_rdata
);

   localparam int NB_LANES = NB_DATA / NB_BYTE;
   localparam int NB_OFF   = $clog2(NB_LANES);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   typedef struct packed {
      logic [NB_OFF-1:0]  offset;
      logic [NB_SIZE-1:0] size;
      logic               is_unsigned;
      logic               is_write;
      logic [NB_ADDR-1:0] address;
   } req_t;

   state_t                state, state_next;
   req_t                  req_q;
   logic [NB_TIMEOUT-1:0] wait_cnt;

   logic                  is_mem, misaligned, accept, done_ack, done_tmo;
   logic [NB_OFF-1:0]     in_offset;
   logic [NB_LANES-1:0]   acc_byte_en;
   logic [NB_DATA-1:0]    acc_wdata, rdata_shifted, load_data;
   int                    acc_bytes, load_bits;

   assign in_offset = i_address[NB_OFF-1:0];
   assign is_mem    = i_read_enable | i_write_enable;

   // A size wider than the bus (dword on a 32-bit bus) is reported as misaligned.
   always_comb begin
      acc_bytes  = 1 << i_size;
      misaligned = (acc_bytes > NB_LANES) || ((int'(in_offset) % acc_bytes) != 0);
      for (int i = 0; i < NB_LANES; i++) begin
         acc_byte_en[i] = (i >= int'(in_offset)) && (i < int'(in_offset) + acc_bytes);
         acc_wdata[i*NB_BYTE +: NB_BYTE] = i_data_write[(i % acc_bytes)*NB_BYTE +: NB_BYTE];
      end
   end

   always_comb begin
      rdata_shifted = i_mem_rdata >> (int'(req_q.offset) * NB_BYTE);
      load_bits     = (1 << req_q.size) * NB_BYTE;
      for (int j = 0; j < NB_DATA; j++) begin
         if (j < load_bits)          load_data[j] = rdata_shifted[j];
         else if (req_q.is_unsigned) load_data[j] = 1'b0;
         else                        load_data[j] = rdata_shifted[load_bits-1];
      end
   end

   assign accept   = (state == IDLE) && i_valid && is_mem && !misaligned;
   assign done_ack = (state == BUSY) && i_mem_ack;
   // Counter value k means k+1 unacknowledged cycles, so the request is held exactly TIMEOUT_CYCLES cycles.
   assign done_tmo = (state == BUSY) && !i_mem_ack &&
                     (wait_cnt == NB_TIMEOUT'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = BUSY;
         BUSY: if (done_ack || done_tmo) state_next = IDLE;
      endcase
   end

   always_comb begin
      o_stall = (state == BUSY) && !i_mem_ack;
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         req_q         <= '0;
         wait_cnt      <= '0;
         o_valid       <= 1'b0;
         o_data        <= '0;
         o_misaligned  <= 1'b0;
         o_timeout     <= 1'b0;
         o_mem_req     <= 1'b0;
         o_mem_we      <= 1'b0;
         o_mem_addr    <= '0;
         o_mem_byte_en <= '0;
         o_mem_wdata   <= '0;
      end else begin
         o_valid      <= 1'b0;
         o_misaligned <= 1'b0;
         o_timeout    <= 1'b0;
         if (state == IDLE && i_valid) begin
            if (!is_mem) begin
               o_valid <= 1'b1;
               o_data  <= NB_DATA'(i_address);
            end else if (misaligned) begin
               o_valid      <= 1'b1;
               o_misaligned <= 1'b1;
               o_data       <= '0;
            end else begin
               req_q <= '{offset: in_offset, size: i_size, is_unsigned: i_is_unsigned,
                          is_write: i_write_enable, address: i_address};
               o_mem_req     <= 1'b1;
               o_mem_we      <= i_write_enable;
               o_mem_addr    <= {i_address[NB_ADDR-1:NB_OFF], {NB_OFF{1'b0}}};
               o_mem_byte_en <= acc_byte_en;
               o_mem_wdata   <= acc_wdata;
            end
         end
         if (done_ack || done_tmo) begin
            o_valid       <= 1'b1;
            o_timeout     <= done_tmo;
            o_data        <= done_tmo ? '0 :
                             (req_q.is_write ? NB_DATA'(req_q.address) : load_data);
            wait_cnt      <= '0;
            o_mem_req     <= 1'b0;
            o_mem_we      <= 1'b0;
            o_mem_addr    <= '0;
            o_mem_byte_en <= '0;
            o_mem_wdata   <= '0;
         end else if (state == BUSY) begin
            wait_cnt <= wait_cnt + NB_TIMEOUT'(1);
         end
      end
   end

endmodule

// File: tb/tb_memory_access_unit.sv
// Bench for memory_access_unit: a 32-bit and a 64-bit instance share stimulus, one active at a time,
// checked against an arithmetic reference model of lane steering, extension, faults and timeout.
module tb_memory_access_unit;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst_n, sel, valid, rd, wr, uns, ack;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [63:0] wdata, rdata;

   logic        stall32, valid32, mis32, tmo32, req32, we32;
   logic [31:0] data32, maddr32, mwd32;
   logic [3:0]  be32;
   logic        stall64, valid64, mis64, tmo64, req64, we64;
   logic [63:0] data64, mwd64;
   logic [31:0] maddr64;
   logic [7:0]  be64;

   logic        obs_stall, obs_valid, obs_mis, obs_tmo, obs_req, obs_we;
   logic [63:0] obs_data, obs_wd;
   logic [31:0] obs_maddr;
   logic [7:0]  obs_be;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   memory_access_unit #(.NB_DATA(32)) u_dut32 (
      .i_clock(clk), .i_reset(rst_n), .i_valid(valid & ~sel),
      .i_read_enable(rd), .i_write_enable(wr), .i_size(size), .i_is_unsigned(uns),
      .i_address(addr), .i_data_write(wdata[31:0]),
      .o_stall(stall32), .o_valid(valid32), .o_data(data32), .o_misaligned(mis32),
      .o_timeout(tmo32), .o_mem_req(req32), .o_mem_we(we32), .o_mem_addr(maddr32),
      .o_mem_byte_en(be32), .o_mem_wdata(mwd32),
      .i_mem_ack(ack & ~sel), .i_mem_rdata(rdata[31:0])
   );

   memory_access_unit #(.NB_DATA(64)) u_dut64 (
      .i_clock(clk), .i_reset(rst_n), .i_valid(valid & sel),
      .i_read_enable(rd), .i_write_enable(wr), .i_size(size), .i_is_unsigned(uns),
      .i_address(addr), .i_data_write(wdata),
      .o_stall(stall64), .o_valid(valid64), .o_data(data64), .o_misaligned(mis64),
      .o_timeout(tmo64), .o_mem_req(req64), .o_mem_we(we64), .o_mem_addr(maddr64),
      .o_mem_byte_en(be64), .o_mem_wdata(mwd64),
      .i_mem_ack(ack & sel), .i_mem_rdata(rdata)
   );

   always_comb begin
      if (sel) begin
         obs_stall = stall64; obs_valid = valid64; obs_mis = mis64; obs_tmo = tmo64;
         obs_req = req64; obs_we = we64; obs_data = data64; obs_wd = mwd64;
         obs_maddr = maddr64; obs_be = be64;
      end else begin
         obs_stall = stall32; obs_valid = valid32; obs_mis = mis32; obs_tmo = tmo32;
         obs_req = req32; obs_we = we32; obs_data = {32'd0, data32}; obs_wd = {32'd0, mwd32};
         obs_maddr = maddr32; obs_be = {4'd0, be32};
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] lane_mask(input int bytes);
      return (bytes >= 8) ? {64{1'b1}} : ((64'd1 << (8 * bytes)) - 64'd1);
   endfunction

   // One complete operation. ack_dly<0 means the memory never answers.
   task automatic run_op(input logic s, input logic is_rd, input logic is_wr, input logic [1:0] sz,
                         input logic u, input logic [31:0] a, input logic [63:0] wd,
                         input int ack_dly, input logic [63:0] rdat);
      int          lanes, bytes, off, stall_cycles;
      logic        mem, mis;
      logic [63:0] bus_mask, exp_be, exp_wd, exp_data, v;
      lanes    = s ? 8 : 4;
      bytes    = 1 << sz;
      off      = int'(a[2:0]) % lanes;
      bus_mask = s ? {64{1'b1}} : 64'h0000_0000_FFFF_FFFF;
      mem      = is_rd | is_wr;
      mis      = mem && ((bytes > lanes) || ((int'(a[3:0]) % bytes) != 0));
      exp_data = '0;
      sel = s; valid = 1'b1; rd = is_rd; wr = is_wr; size = sz; uns = u; addr = a; wdata = wd;
      @(posedge clk); #1;
      valid = 1'b0; rd = 1'b0; wr = 1'b0;
      if (!mem || mis) begin
         check("imm_valid", obs_valid, 1);
         check("imm_mis", obs_mis, mis);
         check("imm_data", obs_data, mem ? 64'd0 : {32'd0, a});
         check("imm_req", obs_req, 0);
         check("imm_stall", obs_stall, 0);
      end else begin
         exp_be = ((64'd1 << bytes) - 64'd1) << off;
         exp_wd = '0;
         for (int k = 0; k < lanes / bytes; k++)
            exp_wd = exp_wd | ((wd & lane_mask(bytes)) << (8 * bytes * k));
         check("req", obs_req, 1);
         check("we", obs_we, is_wr);
         check("maddr", obs_maddr, a - 32'(off));
         check("byte_en", obs_be, exp_be);
         if (is_wr) begin
            check("wdata", obs_wd, exp_wd);
            exp_data = {32'd0, a};
         end else begin
            v = (rdat >> (8 * off)) & lane_mask(bytes);
            if (!u && v[8*bytes-1]) v = v | ~lane_mask(bytes);
            exp_data = v & bus_mask;
         end
         stall_cycles = (ack_dly < 0) ? TMO : ack_dly;
         for (int c = 0; c < stall_cycles; c++) begin
            #1;
            check("stall_hi", obs_stall, 1);
            if (c == stall_cycles - 1) check("req_held", obs_req, 1);
            @(posedge clk); #1;
         end
         if (ack_dly >= 0) begin
            ack = 1'b1; rdata = rdat; #1;
            check("stall_ack", obs_stall, 0);
            @(posedge clk); #1;
            ack = 1'b0;
            check("done_data", obs_data, exp_data);
         end else begin
            check("tmo_data", obs_data, 0);
         end
         check("done_valid", obs_valid, 1);
         check("done_tmo", obs_tmo, ack_dly < 0);
         check("done_mis", obs_mis, 0);
         check("req_drop", obs_req, 0);
      end
      @(posedge clk); #1;
      check("valid_pulse", obs_valid, 0);
   endtask

   initial begin
      logic seen;
      rst_n = 1'b0; sel = 1'b0; valid = 1'b0; rd = 1'b0; wr = 1'b0; uns = 1'b0; ack = 1'b0;
      size = 2'b00; addr = '0; wdata = '0; rdata = '0;
      #12;
      check("rst_valid32", valid32, 0);
      check("rst_data32", data32, 0);
      check("rst_req32", req32, 0);
      check("rst_stall32", stall32, 0);
      check("rst_be64", be64, 0);
      check("rst_data64", data64, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h13, 64'hAB, 3, 64'h0);
      run_op(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h22, 64'h0, 0, 64'h8001_1234);
      run_op(1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 32'h22, 64'h0, 0, 64'h8001_1234);
      run_op(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h06, 64'h0, 0, 64'h0);
      run_op(1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 32'h00, 64'h0, 0, 64'h0);
      run_op(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 64'h0, -1, 64'h0);
      run_op(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h44, 64'h1234_5678, 1, 64'h0);
      run_op(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h1234_5678, 64'h0, 0, 64'h0);

      // An ack while idle must not produce a result.
      sel = 1'b0; ack = 1'b1;
      @(posedge clk); #1;
      ack = 1'b0;
      check("idle_ack_valid", obs_valid, 0);
      check("idle_ack_req", obs_req, 0);

      // Non-memory op, then a load, then an op that must wait behind the load.
      sel = 1'b0; valid = 1'b1; rd = 1'b0; wr = 1'b0; addr = 32'h1234_5678;
      @(posedge clk); #1;
      check("b2b_op1_valid", obs_valid, 1);
      check("b2b_op1_data", obs_data, 64'h1234_5678);
      check("b2b_op1_stall", obs_stall, 0);
      rd = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h100;
      @(posedge clk); #1;
      check("b2b_ld_req", obs_req, 1);
      rd = 1'b0; addr = 32'hCAFE_0000;
      repeat (2) begin
         #1;
         check("b2b_stall", obs_stall, 1);
         @(posedge clk); #1;
      end
      ack = 1'b1; rdata = 64'h5555_AAAA; #1;
      check("b2b_stall_ack", obs_stall, 0);
      @(posedge clk); #1;
      ack = 1'b0;
      check("b2b_ld_valid", obs_valid, 1);
      check("b2b_ld_data", obs_data, 64'h5555_AAAA);
      @(posedge clk); #1;
      valid = 1'b0;
      check("b2b_op3_valid", obs_valid, 1);
      check("b2b_op3_data", obs_data, 64'hCAFE_0000);
      check("b2b_op3_req", obs_req, 0);
      @(posedge clk); #1;

      run_op(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 32'h18, 64'h0, 1, 64'h0123_4567_89AB_CDEF);
      run_op(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0E, 64'hBEEF, 0, 64'h0);

      for (int n = 0; n < 60; n++) begin
         logic        s, r, w, u;
         logic [1:0]  sz;
         logic [31:0] a;
         logic [63:0] d, rv;
         int          kind, dly;
         s    = 1'($urandom_range(0, 1));
         kind = int'($urandom_range(0, 9));
         r    = (kind < 5);
         w    = (kind >= 4) && (kind < 9);
         sz   = 2'($urandom_range(0, 3));
         u    = 1'($urandom_range(0, 1));
         a    = $urandom & 32'h0000_0FFF;
         if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
         d    = {$urandom, $urandom};
         rv   = {$urandom, $urandom};
         if (!s) rv[63:32] = '0;
         dly  = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(0, 4));
         run_op(s, r, w, sz, u, a, d, dly, rv);
      end

      // Reset in the middle of an outstanding 64-bit load.
      sel = 1'b1; valid = 1'b1; rd = 1'b1; size = 2'b11; addr = 32'h40;
      @(posedge clk); #1;
      valid = 1'b0; rd = 1'b0;
      check("busy_req64", req64, 1);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_busy_req", req64, 0);
      check("rst_busy_stall", stall64, 0);
      #2 rst_n = 1'b1;
      seen = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         seen = seen | valid64;
      end
      check("rst_no_valid", seen, 0);
      run_op(1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 32'h24, 64'h0, 2, 64'h8765_4321_0000_0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
